// File: rtl/frame_filter_pkg.sv
// Shared types and constants for the frame-filter datapath.
// Pixel/sideband widths and the stored FIFO entry layout.
package frame_filter_pkg;

    localparam int PIX_W   = 4;
    localparam int TUSER_W = 2;

    localparam logic [TUSER_W-1:0] TUSER_SOF = 2'b11;

    typedef struct packed {
        logic [TUSER_W-1:0] user;
        logic [PIX_W-1:0]   data;
    } entry_t;

endpackage

// File: rtl/rot_fifo_ram.sv
// Register-array storage for rot_fifo.
// One synchronous write port, one asynchronous read port, no reset.
module rot_fifo_ram
    import frame_filter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = PIX_W + TUSER_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rot_fifo.sv
// Circular first-word-fall-through AXI-Stream FIFO.
// Pointers rotate freely; full/empty come from the occupancy counter.
module rot_fifo
    import frame_filter_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int USER_W = TUSER_W,
    parameter int DEPTH  = 16,
    parameter int PW     = $clog2(DEPTH),
    parameter int LW     = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] in_d0,
    input  logic [USER_W-1:0] TUSER,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] out_d0,
    output logic [USER_W-1:0] m_tuser,
    output logic [LW-1:0]     level
);

    localparam int EW = DATA_W + USER_W;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;
    logic [EW-1:0] rd_entry;

    // Ready/valid come from registered level only, so a pop never
    // opens room for a push in the same cycle.
    assign s_tready = (level_q != LW'(DEPTH));
    assign m_tvalid = (level_q != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;
    assign level    = level_q;

    // Head is forced to zero when empty so stale or unwritten
    // entries never show up on the outputs.
    assign out_d0  = m_tvalid ? rd_entry[DATA_W-1:0] : '0;
    assign m_tuser = m_tvalid ? rd_entry[EW-1:DATA_W] : '0;

    rot_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk   (clock),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({TUSER, in_d0}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Next pointer and occupancy from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Control state; reset discards contents immediately.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: tb/tb_rot_fifo.sv
// Self-checking bench for rot_fifo.
// Queue reference model; random and directed scenarios.
module tb_rot_fifo;
    import frame_filter_pkg::*;

    localparam int DEPTH = 16;

    logic       clock;
    logic       resetn;
    logic       s_tvalid;
    logic       s_tready;
    logic [3:0] in_d0;
    logic [1:0] TUSER;
    logic       m_tvalid;
    logic       m_tready;
    logic [3:0] out_d0;
    logic [1:0] m_tuser;
    logic [4:0] level;

    int checks = 0;
    int errors = 0;

    entry_t model_q[$];

    int cov_full_push = 0;
    int cov_pp1 = 0;
    int cov_pp15 = 0;

    rot_fifo dut (
        .clock    (clock),
        .resetn   (resetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .in_d0    (in_d0),
        .TUSER    (TUSER),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .out_d0   (out_d0),
        .m_tuser  (m_tuser),
        .level    (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle and advance the queue model across the edge.
    task automatic cycle(input logic sv, input logic [3:0] d,
                         input logic [1:0] u, input logic mr);
        bit do_push;
        bit do_pop;
        entry_t e;
        s_tvalid = sv;
        in_d0    = d;
        TUSER    = u;
        m_tready = mr;
        do_push  = sv && (model_q.size() < DEPTH);
        do_pop   = mr && (model_q.size() > 0);
        if (sv && model_q.size() == DEPTH) cov_full_push++;
        if (do_push && do_pop && model_q.size() == 1) cov_pp1++;
        if (do_push && do_pop && model_q.size() == 15) cov_pp15++;
        @(posedge clock);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            e.user = u;
            e.data = d;
            model_q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        resetn   = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        in_d0    = '0;
        TUSER    = '0;
        model_q.delete();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold: vld=%b rdy=%b lvl=%0d want 0 1 0",
                     m_tvalid, s_tready, level);
        end
        resetn = 1'b0;
        repeat (3) cycle(1'b0, 4'hA, 2'b01, 1'b1);
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || level !== 5'd0
            || out_d0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: vld=%b rdy=%b lvl=%0d d=%0d want 0 1 0 0",
                     m_tvalid, s_tready, level, out_d0);
        end
    endtask

    task automatic test_fill();
        logic [3:0] d;
        logic [1:0] u;
        for (int i = 0; i < 16; i++) begin
            d = (i < 14) ? 4'(i + 1) : ((i == 14) ? 4'd15 : 4'd0);
            u = (i < 14) ? TUSER_SOF : 2'b00;
            cycle(1'b1, d, u, 1'b0);
            checks++;
            if (level !== 5'(i + 1) || s_tready !== (i != 15)
                || m_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL fill_%0d: lvl=%0d rdy=%b vld=%b want %0d %b 1",
                         i, level, s_tready, m_tvalid, i + 1, i != 15);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd7, 2'b01, 1'b0);
            checks++;
            if (level !== 5'd16 || s_tready !== 1'b0) begin
                errors++;
                $display("FAIL fill_overpush_%0d: lvl=%0d rdy=%b want 16 0",
                         i, level, s_tready);
            end
        end
    endtask

    task automatic test_drain();
        logic [3:0] d;
        logic [1:0] u;
        for (int i = 0; i < 16; i++) begin
            d = (i < 14) ? 4'(i + 1) : ((i == 14) ? 4'd15 : 4'd0);
            u = (i < 14) ? TUSER_SOF : 2'b00;
            checks++;
            if (m_tvalid !== 1'b1 || out_d0 !== d || m_tuser !== u) begin
                errors++;
                $display("FAIL drain_%0d: vld=%b d=%0d u=%0d want 1 %0d %0d",
                         i, m_tvalid, out_d0, m_tuser, d, u);
            end
            cycle(1'b0, 4'd0, 2'b00, 1'b1);
        end
        checks++;
        if (m_tvalid !== 1'b0 || level !== 5'd0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: vld=%b lvl=%0d rdy=%b want 0 0 1",
                     m_tvalid, level, s_tready);
        end
    endtask

    task automatic test_streaming();
        logic [3:0] d;
        logic [1:0] u;
        logic [3:0] prev_d;
        logic [1:0] prev_u;
        prev_d = '0;
        prev_u = '0;
        for (int k = 0; k < 100; k++) begin
            d = 4'((k % 14) + 1);
            u = (k < 14) ? TUSER_SOF : 2'b00;
            if (k > 0) begin
                checks++;
                if (m_tvalid !== 1'b1 || out_d0 !== prev_d
                    || m_tuser !== prev_u || level !== 5'd1) begin
                    errors++;
                    $display("FAIL stream_%0d: vld=%b d=%0d u=%0d lvl=%0d want 1 %0d %0d 1",
                             k, m_tvalid, out_d0, m_tuser, level, prev_d, prev_u);
                end
            end
            cycle(1'b1, d, u, 1'b1);
            prev_d = d;
            prev_u = u;
        end
        cycle(1'b0, 4'd0, 2'b00, 1'b1);
        checks++;
        if (level !== 5'd0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: lvl=%0d vld=%b want 0 0", level, m_tvalid);
        end
    endtask

    task automatic test_random();
        logic sv;
        logic mr;
        int   psv;
        int   pmr;
        int   bad = 0;
        for (int c = 0; c < 1000; c++) begin
            psv = ((c / 100) % 2 == 0) ? 80 : 30;
            pmr = ((c / 100) % 2 == 0) ? 30 : 80;
            sv  = ($urandom_range(99) < psv);
            mr  = ($urandom_range(99) < pmr);
            checks++;
            if (level !== 5'(model_q.size())
                || m_tvalid !== (model_q.size() != 0)
                || s_tready !== (model_q.size() != DEPTH)
                || (model_q.size() != 0
                    && (out_d0 !== model_q[0].data
                        || m_tuser !== model_q[0].user))) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d: lvl=%0d vld=%b rdy=%b d=%0d u=%0d model_lvl=%0d",
                             c, level, m_tvalid, s_tready, out_d0, m_tuser,
                             model_q.size());
            end
            cycle(sv, 4'($urandom), 2'($urandom), mr);
        end
        checks++;
        if (cov_full_push == 0 || cov_pp1 == 0 || cov_pp15 == 0) begin
            errors++;
            $display("FAIL random_coverage: full_push=%0d pp1=%0d pp15=%0d want all >0",
                     cov_full_push, cov_pp1, cov_pp15);
        end
        while (model_q.size() != 0) cycle(1'b0, 4'd0, 2'b00, 1'b1);
        checks++;
        if (level !== 5'd0) begin
            errors++;
            $display("FAIL random_drain: lvl=%0d want 0", level);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 3), 2'b10, 1'b0);
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL midreset_pre: lvl=%0d want 5", level);
        end
        s_tvalid = 1'b0;
        #2;
        resetn = 1'b1;
        #1;
        model_q.delete();
        checks++;
        if (m_tvalid !== 1'b0 || level !== 5'd0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: vld=%b lvl=%0d rdy=%b want 0 0 1",
                     m_tvalid, level, s_tready);
        end
        @(posedge clock);
        #1;
        resetn = 1'b0;
        cycle(1'b1, 4'd9, 2'b00, 1'b0);
        checks++;
        if (m_tvalid !== 1'b1 || out_d0 !== 4'd9 || level !== 5'd1) begin
            errors++;
            $display("FAIL midreset_push: vld=%b d=%0d lvl=%0d want 1 9 1",
                     m_tvalid, out_d0, level);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
